// File: rtl/lcd_timing_pkg.sv
// Shared helpers for the LCD raster generator: axis totals, region
// boundaries and sync polarity mapping.
package lcd_timing_pkg;

  // Total clocks (or lines) in one axis period.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position of the active region (sync and back porch come first).
  function automatic int active_start(input int sync, input int bp);
    return sync + bp;
  endfunction

  // One past the last position of the active region.
  function automatic int active_end(input int sync, input int bp, input int active);
    return sync + bp + active;
  endfunction

  // Map a logical "sync asserted" to the panel's electrical level.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  // Electrical level of a deasserted sync line.
  function automatic logic sync_idle(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register with a per-bit asynchronous reset value.
// Depth 0 degenerates to a straight wire.
module lcd_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    // Next state: each tap takes the previous tap, tap 0 takes the input.
    always_comb begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    // Shift on every clock; reset flushes every tap to the idle pattern.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          sr_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          sr_q[i] <= sr_d[i];
        end
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD raster generator. Walks an h/v raster (sync, back
// porch, active, front porch per axis), flags pixels inside a movable
// image window, and issues frame-buffer reads RD_LAT clocks ahead of the
// display-side timing so RAM data lands together with lcd_de/img_de.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int CNT_W    = 12,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              en,
  input  logic [CNT_W-1:0]  img_x,
  input  logic [CNT_W-1:0]  img_y,
  output logic              lcd_pwm,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic              img_de,
  output logic [CNT_W-1:0]  xofs,
  output logic [CNT_W-1:0]  yofs,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_start
);

  localparam int CW1   = CNT_W + 1;
  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Boundaries held one bit wider than the counters so window-edge sums
  // (wx + IMG_W) cannot wrap.
  localparam logic [CNT_W:0] H_LAST   = CW1'(H_TOT - 1);
  localparam logic [CNT_W:0] V_LAST   = CW1'(V_TOT - 1);
  localparam logic [CNT_W:0] H_SYNC_E = CW1'(H_SYNC);
  localparam logic [CNT_W:0] V_SYNC_E = CW1'(V_SYNC);
  localparam logic [CNT_W:0] H_ACT_S  = CW1'(active_start(H_SYNC, H_BP));
  localparam logic [CNT_W:0] H_ACT_E  = CW1'(active_end(H_SYNC, H_BP, H_ACTIVE));
  localparam logic [CNT_W:0] V_ACT_S  = CW1'(active_start(V_SYNC, V_BP));
  localparam logic [CNT_W:0] V_ACT_E  = CW1'(active_end(V_SYNC, V_BP, V_ACTIVE));
  localparam logic [CNT_W:0] IMG_W_E  = CW1'(IMG_W);
  localparam logic [CNT_W:0] IMG_H_E  = CW1'(IMG_H);

  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  localparam logic HS_POL_L = (HS_POL != 0);
  localparam logic VS_POL_L = (VS_POL != 0);

  // Display bundle order: {frame_start, img_de, lcd_de, vs, hs, yofs, xofs}
  localparam int PIPE_W = 5 + 2 * CNT_W;
  localparam logic [PIPE_W-1:0] PIPE_RST =
    {1'b0, 1'b0, 1'b0, sync_idle(VS_POL_L), sync_idle(HS_POL_L), {(2*CNT_W){1'b0}}};

  // Raster counters and latched window origin
  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0]  wx_q, wx_d, wy_q, wy_d;

  // Incremental read-address generation
  logic [ADDR_W-1:0] base_q, base_d, col_q, col_d, addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              pwm_q, pwm_d;

  // Stage-0 display-side signals
  logic              de_p0_q, de_p0_d, img_p0_q, img_p0_d, fs_p0_q, fs_p0_d;
  logic              hs_p0_q, hs_p0_d, vs_p0_q, vs_p0_d;
  logic [CNT_W-1:0]  x_p0_q, x_p0_d, y_p0_q, y_p0_d;

  // Raster decode
  logic [CNT_W:0]    h_e, v_e, x_e, y_e, wx_e, wy_e;
  logic              at_origin, line_end, h_act, v_act, in_x, in_y;
  logic              win_pix, win_row;
  logic              unused_msb;

  // Decode the current raster position into regions and window membership.
  always_comb begin
    h_e       = {1'b0, h_q};
    v_e       = {1'b0, v_q};
    wx_e      = {1'b0, wx_q};
    wy_e      = {1'b0, wy_q};
    x_e       = h_e - H_ACT_S;
    y_e       = v_e - V_ACT_S;
    at_origin = (h_q == '0) && (v_q == '0);
    line_end  = (h_e == H_LAST);
    h_act     = (h_e >= H_ACT_S) && (h_e < H_ACT_E);
    v_act     = (v_e >= V_ACT_S) && (v_e < V_ACT_E);
    in_x      = (x_e >= wx_e) && (x_e < wx_e + IMG_W_E);
    in_y      = (y_e >= wy_e) && (y_e < wy_e + IMG_H_E);
    // Window geometry ignores en so the address stays position-exact even
    // when en drops and rises again inside a frame.
    win_pix   = h_act && v_act && in_x && in_y;
    win_row   = v_act && in_y;
  end

  assign unused_msb = x_e[CNT_W] ^ y_e[CNT_W];

  // Advance h/v; with en low, park at the origin once the frame completes.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en || !at_origin) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_e == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Window origin is taken from the inputs only while sitting at the origin.
  always_comb begin
    wx_d  = at_origin ? img_x : wx_q;
    wy_d  = at_origin ? img_y : wy_q;
    pwm_d = 1'b1;
  end

  // Stage-0 display signals, forced idle while en is low.
  always_comb begin
    de_p0_d  = en && h_act && v_act;
    img_p0_d = en && win_pix;
    fs_p0_d  = en && at_origin;
    hs_p0_d  = sync_level(en && (h_e < H_SYNC_E), HS_POL_L);
    vs_p0_d  = sync_level(en && (v_e < V_SYNC_E), VS_POL_L);
    x_p0_d   = de_p0_d ? x_e[CNT_W-1:0] : '0;
    y_p0_d   = de_p0_d ? y_e[CNT_W-1:0] : '0;
  end

  // Read address = row base + column; base steps by IMG_W per window row,
  // so no multiplier is needed. Address holds between reads.
  always_comb begin
    base_d  = base_q;
    col_d   = col_q;
    addr_d  = addr_q;
    rd_en_d = en && win_pix;
    if (win_pix) begin
      col_d = col_q + 1'b1;
    end
    if (en && win_pix) begin
      addr_d = base_q + col_q;
    end
    if (line_end) begin
      col_d = '0;
      if (win_row) begin
        base_d = base_q + IMG_W_A;
      end
    end
    if (at_origin) begin
      base_d = '0;
      col_d  = '0;
      addr_d = '0;
    end
  end

  // ---- stage 0 boundary: counters, window, read port and display stage 0 ----
  // All state registers; reset drops everything to the idle raster.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      h_q      <= '0;
      v_q      <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      base_q   <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      pwm_q    <= 1'b0;
      de_p0_q  <= 1'b0;
      img_p0_q <= 1'b0;
      fs_p0_q  <= 1'b0;
      hs_p0_q  <= sync_idle(HS_POL_L);
      vs_p0_q  <= sync_idle(VS_POL_L);
      x_p0_q   <= '0;
      y_p0_q   <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      base_q   <= base_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      pwm_q    <= pwm_d;
      de_p0_q  <= de_p0_d;
      img_p0_q <= img_p0_d;
      fs_p0_q  <= fs_p0_d;
      hs_p0_q  <= hs_p0_d;
      vs_p0_q  <= vs_p0_d;
      x_p0_q   <= x_p0_d;
      y_p0_q   <= y_p0_d;
    end
  end

  // ---- stages 1..RD_LAT: align display timing with RAM read data ----
  logic [PIPE_W-1:0] pipe_p0, pipe_out;

  assign pipe_p0 = {fs_p0_q, img_p0_q, de_p0_q, vs_p0_q, hs_p0_q, y_p0_q, x_p0_q};

  lcd_delay_line #(
    .W       (PIPE_W),
    .DEPTH   (RD_LAT),
    .RST_VAL (PIPE_RST)
  ) u_align (
    .clk (clk),
    .rst (rest),
    .d   (pipe_p0),
    .q   (pipe_out)
  );

  assign {frame_start, img_de, lcd_de, lcd_vs, lcd_hs, yofs, xofs} = pipe_out;

  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign lcd_pwm = pwm_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomised bench for lcd_timing_gen on a small 14x7 raster. A frame
// position model (pos = clocks since frame start) predicts every output.
module tb_lcd_timing_gen;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HPOL = 1, VPOL = 0;
  localparam int IW = 3, IH = 2;
  localparam int CW = 8, AW = 8, LAT = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rest, en;
  logic [CW-1:0] img_x, img_y;
  logic          lcd_pwm, lcd_hs, lcd_vs, lcd_de, img_de, rd_en, frame_start;
  logic [CW-1:0] xofs, yofs;
  logic [AW-1:0] addr;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL), .IMG_W(IW), .IMG_H(IH),
    .CNT_W(CW), .ADDR_W(AW), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rest(rest), .en(en), .img_x(img_x), .img_y(img_y),
    .lcd_pwm(lcd_pwm), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .img_de(img_de), .xofs(xofs), .yofs(yofs), .rd_en(rd_en), .addr(addr),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic          fs, img, de, vs, hs;
    logic [CW-1:0] x, y;
    logic [AW-1:0] a;
  } rec_t;

  function automatic rec_t idle_rec();
    rec_t r;
    r    = '0;
    r.hs = (HPOL == 0);
    r.vs = (VPOL == 0);
    return r;
  endfunction

  // Expected display-side values for frame position pos.
  function automatic rec_t raster(input int pos, input logic e, input int wx, input int wy);
    rec_t r;
    int h, v, x, y;
    r = idle_rec();
    h = pos % HT;
    v = pos / HT;
    x = h - (HSY + HBP);
    y = v - (VSY + VBP);
    if (e) begin
      r.hs = ((h < HSY) == (HPOL != 0));
      r.vs = ((v < VSY) == (VPOL != 0));
      r.fs = (pos == 0);
      r.de = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
      if (r.de) begin
        r.x   = CW'(x);
        r.y   = CW'(y);
        r.img = (x >= wx) && (x < wx + IW) && (y >= wy) && (y < wy + IH);
        r.a   = AW'((y - wy) * IW + (x - wx));
      end
    end
    return r;
  endfunction

  // Model state
  int            m_pos, m_wx, m_wy;
  rec_t          hist [0:LAT];
  logic [AW-1:0] m_addr;
  logic          m_rd, m_pwm;
  rec_t          cur;
  logic [AW-1:0] ram [0:LAT-1];

  assign cur = raster(m_pos, en, m_wx, m_wy);

  always @(posedge clk) begin
    if (rest) begin
      m_pos  <= 0;
      m_wx   <= 0;
      m_wy   <= 0;
      m_addr <= '0;
      m_rd   <= 1'b0;
      m_pwm  <= 1'b0;
      for (int i = 0; i <= LAT; i++) hist[i] <= idle_rec();
    end else begin
      hist[0] <= cur;
      for (int i = 1; i <= LAT; i++) hist[i] <= hist[i-1];
      m_rd  <= cur.img;
      m_pwm <= 1'b1;
      if (cur.img) m_addr <= cur.a;
      else if (m_pos == 0) m_addr <= '0;
      if (m_pos == 0) begin
        m_wx <= int'(img_x);
        m_wy <= int'(img_y);
      end
      if (en || m_pos != 0) m_pos <= (m_pos + 1) % FRAME;
    end
  end

  // RAM of latency LAT whose data word equals the address it was given.
  always @(posedge clk) begin
    ram[0] <= addr;
    for (int i = 1; i < LAT; i++) ram[i] <= ram[i-1];
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-frame statistics between successive frame_start pulses
  bit measure = 1'b0, have_prev = 1'b0;
  int fs_gap = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  task automatic check_cycle();
    rec_t e;
    e = hist[LAT];
    chk("lcd_hs",      32'(lcd_hs),      32'(e.hs));
    chk("lcd_vs",      32'(lcd_vs),      32'(e.vs));
    chk("lcd_de",      32'(lcd_de),      32'(e.de));
    chk("img_de",      32'(img_de),      32'(e.img));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("xofs",        32'(xofs),        32'(e.x));
    chk("yofs",        32'(yofs),        32'(e.y));
    chk("rd_en",       32'(rd_en),       32'(m_rd));
    chk("addr",        32'(addr),        32'(m_addr));
    chk("lcd_pwm",     32'(lcd_pwm),     32'(m_pwm));
    if (e.img) chk("ram_data", 32'(ram[LAT-1]), 32'(e.a));
    if (frame_start) begin
      if (measure && have_prev) begin
        chk("fs_gap",        32'(fs_gap), 32'(FRAME));
        chk("de_per_frame",  32'(de_cnt), 32'(HA * VA));
        chk("hs_act_clocks", 32'(hs_cnt), 32'(HSY * VT));
        chk("vs_act_clocks", 32'(vs_cnt), 32'(VSY * HT));
      end
      have_prev = measure;
      fs_gap = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end
    fs_gap++;
    if (lcd_de) de_cnt++;
    if (lcd_hs == (HPOL != 0)) hs_cnt++;
    if (lcd_vs == (VPOL != 0)) vs_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rest = 1'b1; en = 1'b1; img_x = CW'(2); img_y = CW'(1);
    measure = 1'b1;
    run(3);
    chk("rst_hs",   32'(lcd_hs),  32'(0));
    chk("rst_vs",   32'(lcd_vs),  32'(1));
    chk("rst_pwm",  32'(lcd_pwm), 32'(0));
    chk("rst_addr", 32'(addr),    32'(0));
    rest = 1'b0;
    run(3 * FRAME);

    // Window origin moves at random times; only frame-start values apply.
    for (int c = 0; c < 10 * FRAME; c++) begin
      tick();
      if ($urandom_range(0, 15) == 0) begin
        img_x = CW'($urandom_range(0, 9));
        img_y = CW'($urandom_range(0, 4));
      end
    end

    // Window clipped at the right edge
    img_x = CW'(7); img_y = CW'(1);
    run(3 * FRAME);

    // Reset in the middle of an active line
    measure = 1'b0;
    begin
      int k;
      k = 0;
      while (!lcd_de && k < FRAME) begin tick(); k++; end
      if (!lcd_de) chk("wait_lcd_de", 32'(lcd_de), 32'(1));
    end
    run(3);
    rest = 1'b1;
    run(2);
    chk("midrst_de", 32'(lcd_de), 32'(0));
    chk("midrst_rd", 32'(rd_en),  32'(0));
    rest = 1'b0;
    img_x = CW'(2); img_y = CW'(1);
    run(2 * FRAME);

    // en low for 200 clocks: raster parks, outputs idle
    en = 1'b0;
    run(200);
    chk("en0_de", 32'(lcd_de),      32'(0));
    chk("en0_rd", 32'(rd_en),       32'(0));
    chk("en0_fs", 32'(frame_start), 32'(0));
    chk("en0_hs", 32'(lcd_hs),      32'(0));
    en = 1'b1;
    run(2 * FRAME);

    // Random en toggling
    for (int c = 0; c < 4 * FRAME; c++) begin
      tick();
      if ($urandom_range(0, 31) == 0) en = ~en;
      if ($urandom_range(0, 63) == 0) img_x = CW'($urandom_range(0, 9));
    end
    en = 1'b1;
    measure = 1'b1;
    run(4 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
